// File: rtl/motion_update_broadcaster.sv
// Transmit end of the motion-update bus: sweeps every cell, applies one velocity step
// with periodic wrap, and broadcasts each particle's new position and destination cell.
module motion_update_broadcaster #(
  parameter int DATA_WIDTH    = 32,
  parameter int OFFSET_WIDTH  = 8,
  parameter int NUM_CELL      = 4,
  parameter int CELL_ID_WIDTH = 4,
  parameter int ADDR_WIDTH    = 8,
  parameter int PARTICLE_NUM  = 220
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [3*CELL_ID_WIDTH-1:0] rd_cell_id,
  output logic [ADDR_WIDTH-1:0]      rd_address,
  output logic                       rd_en,
  input  logic [3*DATA_WIDTH-1:0]    in_pos,
  input  logic [3*DATA_WIDTH-1:0]    in_vel,
  output logic                       motion_update_enable,
  output logic [3*DATA_WIDTH-1:0]    out_data,
  output logic [3*CELL_ID_WIDTH-1:0] out_data_dst_cell,
  output logic                       out_data_valid,
  output logic                       busy,
  output logic                       done
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RD_CNT    = 3'd1;
  localparam logic [2:0] S_WAIT_CNT  = 3'd2;
  localparam logic [2:0] S_STREAM    = 3'd3;
  localparam logic [2:0] S_DRAIN     = 3'd4;
  localparam logic [2:0] S_NEXT_CELL = 3'd5;
  localparam logic [2:0] S_FINISH    = 3'd6;

  localparam logic signed [DATA_WIDTH:0] BOX_LEN = (DATA_WIDTH+1)'(NUM_CELL << OFFSET_WIDTH);
  localparam logic [CELL_ID_WIDTH-1:0]   LAST_ID = CELL_ID_WIDTH'(NUM_CELL);
  localparam logic [CELL_ID_WIDTH-1:0]   FIRST_ID = CELL_ID_WIDTH'(1);

  logic [2:0]                     r_state;
  logic [CELL_ID_WIDTH-1:0]       r_cell_x, r_cell_y, r_cell_z;
  logic [ADDR_WIDTH-1:0]          r_count, r_addr;
  logic [1:0]                     r_wait;
  logic                           r_rd_part;
  logic                           r_busy, r_enable, r_done;
  logic [3*DATA_WIDTH-1:0]        r_out_data;
  logic [3*CELL_ID_WIDTH-1:0]     r_out_dst;
  logic                           r_out_valid;

  logic                           w_last_cell;
  logic [ADDR_WIDTH-1:0]          w_count;
  logic [3*DATA_WIDTH-1:0]        w_new_pos;
  logic [3*CELL_ID_WIDTH-1:0]     w_dst;

  assign rd_en      = (r_state == S_RD_CNT) || (r_state == S_STREAM);
  assign rd_address = (r_state == S_STREAM) ? r_addr : '0;
  assign rd_cell_id = rd_en ? {r_cell_x, r_cell_y, r_cell_z} : '0;

  assign motion_update_enable = r_enable;
  assign out_data             = r_out_data;
  assign out_data_dst_cell    = r_out_dst;
  assign out_data_valid       = r_out_valid;
  assign busy                 = r_busy;
  assign done                 = r_done;

  assign w_last_cell = (r_cell_x == LAST_ID) && (r_cell_y == LAST_ID) && (r_cell_z == LAST_ID);
  assign w_count = (in_pos[DATA_WIDTH-1:0] > DATA_WIDTH'(PARTICLE_NUM)) ?
                   ADDR_WIDTH'(PARTICLE_NUM) : in_pos[ADDR_WIDTH-1:0];

  // Axis gi = 0/1/2 is x/y/z; data buses are {z,y,x} but cell IDs are {x,y,z}.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_axis
      logic signed [DATA_WIDTH:0] w_sum;
      logic [DATA_WIDTH-1:0]      w_wrapped;

      assign w_sum = $signed({1'b0, in_pos[gi*DATA_WIDTH +: DATA_WIDTH]})
                   + $signed({in_vel[gi*DATA_WIDTH+DATA_WIDTH-1], in_vel[gi*DATA_WIDTH +: DATA_WIDTH]});

      always_comb begin
        w_wrapped = w_sum[DATA_WIDTH-1:0];
        if (w_sum < 0)
          w_wrapped = DATA_WIDTH'(w_sum + BOX_LEN);
        else if (w_sum >= BOX_LEN)
          w_wrapped = DATA_WIDTH'(w_sum - BOX_LEN);
      end

      assign w_new_pos[gi*DATA_WIDTH +: DATA_WIDTH] = w_wrapped;
      assign w_dst[(2-gi)*CELL_ID_WIDTH +: CELL_ID_WIDTH] =
        CELL_ID_WIDTH'((w_wrapped >> OFFSET_WIDTH) + DATA_WIDTH'(1));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cell_x    <= FIRST_ID;
      r_cell_y    <= FIRST_ID;
      r_cell_z    <= FIRST_ID;
      r_count     <= '0;
      r_addr      <= '0;
      r_wait      <= '0;
      r_rd_part   <= 1'b0;
      r_busy      <= 1'b0;
      r_enable    <= 1'b0;
      r_done      <= 1'b0;
      r_out_data  <= '0;
      r_out_dst   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      // Read data lands one cycle after a particle read; result is registered the next.
      r_done      <= 1'b0;
      r_rd_part   <= (r_state == S_STREAM);
      r_out_valid <= r_rd_part;
      r_out_data  <= r_rd_part ? w_new_pos : '0;
      r_out_dst   <= r_rd_part ? w_dst : '0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy   <= 1'b1;
            r_enable <= 1'b1;
            r_state  <= S_RD_CNT;
          end
        end
        S_RD_CNT: r_state <= S_WAIT_CNT;
        S_WAIT_CNT: begin
          r_count <= w_count;
          r_addr  <= ADDR_WIDTH'(1);
          r_state <= (w_count == '0) ? S_NEXT_CELL : S_STREAM;
        end
        S_STREAM: begin
          if (r_addr == r_count) begin
            r_wait  <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (r_wait == 2'd1) r_state <= S_NEXT_CELL;
          else                r_wait  <= r_wait + 2'd1;
        end
        S_NEXT_CELL: begin
          if (r_cell_z != LAST_ID) begin
            r_cell_z <= r_cell_z + FIRST_ID;
          end else begin
            r_cell_z <= FIRST_ID;
            if (r_cell_y != LAST_ID) begin
              r_cell_y <= r_cell_y + FIRST_ID;
            end else begin
              r_cell_y <= FIRST_ID;
              r_cell_x <= (r_cell_x != LAST_ID) ? r_cell_x + FIRST_ID : FIRST_ID;
            end
          end
          if (w_last_cell) begin
            r_enable <= 1'b0;
            r_wait   <= '0;
            r_state  <= S_FINISH;
          end else begin
            r_state <= S_RD_CNT;
          end
        end
        S_FINISH: begin
          // Hold while receivers count their writes and swap buffers.
          if (r_wait == 2'd2) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
